// File: rtl/arb_pkg.sv
// Shared types and parameter defaults for the round-robin cacheline arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned NUM_PORTS_DEF  = 2;
  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned LINE_WIDTH_DEF = 256;

endpackage

// File: rtl/rr_line_arbiter_if.sv
// Upstream cache ports plus the downstream memory port of the line arbiter.
interface rr_line_arbiter_if
  import arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = NUM_PORTS_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEF
) ();

  logic [NUM_PORTS-1:0]                 up_read;
  logic [NUM_PORTS-1:0]                 up_write;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] up_address;
  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0] up_wdata;
  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0] up_rdata;
  logic [NUM_PORTS-1:0]                 up_resp;

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;

  logic                  abort_err;

  // Arbiter side.
  modport slave (
    input  up_read, up_write, up_address, up_wdata, mem_rdata, mem_resp,
    output up_rdata, up_resp, mem_read, mem_write, mem_address, mem_wdata, abort_err
  );

  // Caches plus memory side.
  modport master (
    output up_read, up_write, up_address, up_wdata, mem_rdata, mem_resp,
    input  up_rdata, up_resp, mem_read, mem_write, mem_address, mem_wdata, abort_err
  );

endinterface

// File: rtl/rr_priority_select.sv
// Finds the first eligible requester scanning upward from a start index, wrapping modulo N.
module rr_priority_select #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  input  logic [N-1:0]     excl,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  // Rotate the eligible set so bit 0 is the start port, then take the lowest set bit.
  always_comb begin
    dbl   = {req & ~excl, req & ~excl};
    rot   = N'(dbl >> start);
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid && rot[i]) begin
        valid = 1'b1;
        idx   = IDX_W'((32'(start) + i) % N);
      end
    end
  end

endmodule

// File: rtl/rr_line_arbiter.sv
// Round-robin arbiter multiplexing several cache line ports onto one memory port.
module rr_line_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = NUM_PORTS_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEF
) (
  input logic               clk,
  input logic               rst,
  rr_line_arbiter_if.slave  bus
);

  localparam int unsigned     IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     g_q, g_d;
  logic [IDX_W-1:0]     last_q, last_d;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] g_onehot;
  logic [NUM_PORTS-1:0] excl;
  logic [IDX_W-1:0]     start_idx;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_valid;
  logic                 busy;
  logic                 g_req;
  logic                 abort_c;

  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [LINE_WIDTH-1:0] wdata_mux;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == LAST_PORT) ? '0 : IDX_W'(i + 1'b1);
  endfunction

  assign req  = bus.up_read | bus.up_write;
  assign busy = (state_q == BUSY);

  always_comb begin
    g_onehot = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      g_onehot[p] = (g_q == IDX_W'(p));
    end
  end

  assign g_req = |(req & g_onehot);

  // One selector serves both the idle pick (after last) and the handoff pick (after g, g excluded).
  assign start_idx = busy ? next_idx(g_q) : next_idx(last_q);
  assign excl      = busy ? g_onehot : '0;

  rr_priority_select #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_sel (
    .req   (req),
    .start (start_idx),
    .excl  (excl),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    abort_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d = BUSY;
          g_d     = sel_idx;
        end
      end
      BUSY: begin
        if (bus.mem_resp) begin
          last_d = g_q;
          if (sel_valid) begin
            g_d = sel_idx;
          end else begin
            state_d = IDLE;
          end
        end else if (!g_req) begin
          abort_c = 1'b1;
          last_d  = g_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      last_q  <= LAST_PORT;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
    end
  end

  // Downstream mux: transparent from the granted port while BUSY, zero otherwise.
  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (busy && g_onehot[p]) begin
        addr_mux  = bus.up_address[p];
        wdata_mux = bus.up_wdata[p];
      end
    end
  end

  assign bus.mem_read    = busy & |(bus.up_read & g_onehot);
  assign bus.mem_write   = busy & |(bus.up_write & g_onehot);
  assign bus.mem_address = addr_mux;
  assign bus.mem_wdata   = wdata_mux;
  assign bus.abort_err   = abort_c;

  always_comb begin
    bus.up_resp  = '0;
    bus.up_rdata = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (busy && g_onehot[p]) begin
        bus.up_resp[p]  = bus.mem_resp;
        bus.up_rdata[p] = bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_rr_line_arbiter.sv
// Scoreboard bench for rr_line_arbiter: expected grants queued at request time, checked on up_resp.
module tb_rr_line_arbiter;
  import arb_pkg::*;

  localparam int unsigned NP = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;

  typedef struct {
    int              port;
    bit              wr;
    logic [AW-1:0]   addr;
    logic [LW-1:0]   wdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rr_line_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  rr_line_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t          exp_q[$];
  logic [NP-1:0] sr, sw;
  logic [AW-1:0] sa  [NP];
  logic [LW-1:0] swd [NP];
  int            reps[NP];
  int            lat;
  int            age;
  bit            resp_prev;
  bit            resp_seen_prev;
  bit            exp_abort;
  bit            chk_handoff;
  int            n_checks = 0;
  int            n_pass   = 0;

  function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
    return {8{a ^ 32'h0000_1000}} ^ {32{8'hA5}};
  endfunction

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  task automatic request(input int p, input bit wr, input logic [AW-1:0] a,
                         input logic [LW-1:0] d, input int n);
    sr[p] = !wr; sw[p] = wr; sa[p] = a; swd[p] = d; reps[p] = n;
  endtask

  task automatic expect_grant(input int p);
    exp_t e;
    e.port = p; e.wr = sw[p]; e.addr = sa[p]; e.wdata = swd[p];
    exp_q.push_back(e);
  endtask

  task automatic observe();
    bit   strobe;
    int   p;
    exp_t e;
    if (rst) return;
    strobe = bus.mem_read | bus.mem_write;
    check("abort_err", bus.abort_err, exp_abort);
    if (chk_handoff && resp_seen_prev && exp_q.size() > 0) check("handoff_no_bubble", strobe, 1'b1);
    if (strobe) begin
      if (exp_q.size() == 0) check("grant_unexpected", strobe, 1'b0);
      else begin
        e = exp_q[0];
        check("mem_read", bus.mem_read, !e.wr);
        check("mem_write", bus.mem_write, e.wr);
        check("mem_address", bus.mem_address, e.addr);
        check("mem_wdata", bus.mem_wdata, e.wdata);
      end
    end
    check("up_resp_onehot", ($countones(bus.up_resp) <= 1), 1'b1);
    p = -1;
    for (int i = 0; i < NP; i++) if (bus.up_resp[i]) p = i;
    if (p >= 0) begin
      if (exp_q.size() == 0) check("resp_unexpected", bus.up_resp, '0);
      else begin
        e = exp_q.pop_front();
        check("resp_port", p, e.port);
        for (int i = 0; i < NP; i++)
          check("up_rdata_lane", bus.up_rdata[i], (i == p) ? mem_line(e.addr) : '0);
      end
      reps[p]--;
      if (reps[p] <= 0) begin sr[p] = 1'b0; sw[p] = 1'b0; end
    end else begin
      check("up_rdata_quiet", |bus.up_rdata, 1'b0);
    end
    resp_seen_prev = (p >= 0);
  endtask

  // One clock: apply port shadows, run the memory model, then sample at negedge.
  task automatic tick();
    @(posedge clk); #1;
    bus.up_read  = sr;
    bus.up_write = sw;
    for (int p = 0; p < NP; p++) begin
      bus.up_address[p] = sa[p];
      bus.up_wdata[p]   = swd[p];
    end
    #1;
    if (resp_prev) age = 0;
    if (bus.mem_read | bus.mem_write) age++; else age = 0;
    bus.mem_resp  = (bus.mem_read | bus.mem_write) && (age >= lat);
    bus.mem_rdata = bus.mem_resp ? mem_line(bus.mem_address) : '0;
    resp_prev = bus.mem_resp;
    @(negedge clk);
    observe();
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || (sr | sw) != '0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      check("timeout_pending_grants", exp_q.size(), 0);
      check("timeout_pending_requests", sr | sw, '0);
      exp_q.delete();
      sr = '0; sw = '0;
    end
    tick();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mem_read"}, bus.mem_read, 1'b0);
    check({tag, "_mem_write"}, bus.mem_write, 1'b0);
    check({tag, "_mem_address"}, bus.mem_address, '0);
    check({tag, "_up_resp"}, bus.up_resp, '0);
    check({tag, "_up_rdata"}, |bus.up_rdata, 1'b0);
    check({tag, "_abort_err"}, bus.abort_err, 1'b0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    sr = '0; sw = '0;
    for (int p = 0; p < NP; p++) begin sa[p] = '0; swd[p] = '0; reps[p] = 0; end
    bus.up_read = '0; bus.up_write = '0; bus.up_address = '0; bus.up_wdata = '0;
    bus.mem_resp = 1'b0; bus.mem_rdata = '0;
    exp_q.delete();
    age = 0; resp_prev = 1'b0; resp_seen_prev = 1'b0; exp_abort = 1'b0; chk_handoff = 1'b0;
    #1;
    check_quiet("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    lat = 2;
    reset_dut();

    // Single read from port 0 with one-cycle arbitration latency.
    lat = 3;
    request(0, 1'b0, 32'h0000_1000, '0, 1);
    expect_grant(0);
    tick();
    check("arb_latency_c0", bus.mem_read, 1'b0);
    tick();
    check("arb_latency_c1", bus.mem_read, 1'b1);
    run(20);

    // Two simultaneous requesters: port 0 first, port 1 handed off with no idle gap.
    reset_dut();
    lat = 2;
    request(0, 1'b0, 32'h0000_3000, '0, 1);
    request(1, 1'b0, 32'h0000_3100, '0, 1);
    expect_grant(0);
    expect_grant(1);
    chk_handoff = 1'b1;
    run(30);
    chk_handoff = 1'b0;

    // All four ports request continuously: strict rotation 0,1,2,3,0,1,2,3.
    reset_dut();
    lat = 1;
    for (int p = 0; p < NP; p++) request(p, 1'b0, AW'(32'h4000 + p * 32'h40), '0, 2);
    for (int k = 0; k < 2; k++) for (int p = 0; p < NP; p++) expect_grant(p);
    chk_handoff = 1'b1;
    run(100);
    chk_handoff = 1'b0;

    // Write forwarding from port 1.
    lat = 2;
    request(1, 1'b1, 32'h0000_2040, {8{32'h1234_5678}}, 1);
    expect_grant(1);
    run(20);

    // Abort: port 0 drops its read mid-transaction; next search starts at port 1.
    reset_dut();
    lat = 10;
    request(0, 1'b0, 32'h0000_5000, '0, 1);
    expect_grant(0);
    repeat (3) tick();
    sr[0] = 1'b0;
    void'(exp_q.pop_front());
    exp_abort = 1'b1;
    tick();
    exp_abort = 1'b0;
    lat = 2;
    request(0, 1'b0, 32'h0000_5000, '0, 1);
    request(1, 1'b0, 32'h0000_5100, '0, 1);
    expect_grant(1);
    expect_grant(0);
    tick();
    check("abort_then_idle", bus.mem_read | bus.mem_write, 1'b0);
    run(30);

    // Reset during a read: outputs clear immediately and port 0 wins afterwards.
    reset_dut();
    lat = 2;
    request(1, 1'b0, 32'h0000_6100, '0, 1);
    expect_grant(1);
    run(20);
    lat = 20;
    request(0, 1'b0, 32'h0000_6000, '0, 1);
    request(2, 1'b0, 32'h0000_6200, '0, 1);
    expect_grant(2);
    repeat (3) tick();
    check("pre_reset_busy", bus.mem_read, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_quiet("async_reset");
    exp_q.delete();
    age = 0; resp_prev = 1'b0; resp_seen_prev = 1'b0;
    bus.mem_resp = 1'b0; bus.mem_rdata = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    lat = 2;
    expect_grant(0);
    expect_grant(2);
    run(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
